// File: rtl/mult_pipe_hs.sv
// Handshaked pipelined multiplier with bubble-collapsing backpressure.
// Operands are sign- or zero-extended in S0, multiplied into S1, then shifted to the output stage.
module mult_pipe_hs #(
    parameter int WIDTH = 8,
    parameter int LAT   = 3,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_signed,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         out_product,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(LAT+1)-1:0]   occupancy
);

    localparam int PW    = 2 * WIDTH;
    localparam int OCC_W = $clog2(LAT + 1);

    function automatic logic signed [PW-1:0] extend(input logic [WIDTH-1:0] x, input logic sgn);
        extend = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    endfunction

    // Low PW bits of the extended product are exact for both signed and unsigned modes.
    function automatic logic [PW-1:0] mul_lo(input logic signed [PW-1:0] a, input logic signed [PW-1:0] b);
        logic signed [PW-1:0] p;
        p = a * b;
        return p;
    endfunction

    logic [LAT-1:0]        vld_q;
    logic [LAT-1:0]        adv;
    logic signed [PW-1:0]  opa_q;
    logic signed [PW-1:0]  opb_q;
    logic [PW-1:0]         prod_q [1:LAT-1];
    logic [PW-1:0]         prod_d [1:LAT-1];
    logic [TAG_W-1:0]      tag_q  [LAT];
    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      occ_d;
    logic                  accept;
    logic                  fire;

    // A stage may advance when any stage at or downstream of it is empty, or the output drains.
    always_comb begin
        logic hole;
        hole = 1'b0;
        adv  = '0;
        for (int k = LAT - 1; k >= 0; k--) begin
            hole   = hole | ~vld_q[k];
            adv[k] = hole | out_ready;
        end
    end

    assign in_ready = !rst && adv[0];
    assign accept   = in_valid && in_ready;
    assign fire     = vld_q[LAT-1] && out_ready;

    always_comb begin
        prod_d[1] = mul_lo(opa_q, opb_q);
        for (int k = 2; k < LAT; k++) begin
            prod_d[k] = prod_q[k-1];
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (accept && !fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (fire && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Only control and the visible output stage are cleared; interior payload just holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q          <= '0;
            occ_q          <= '0;
            prod_q[LAT-1]  <= '0;
            tag_q[LAT-1]   <= '0;
        end else begin
            occ_q <= occ_d;
            if (adv[0]) begin
                vld_q[0] <= accept;
                opa_q    <= extend(in_a, in_signed);
                opb_q    <= extend(in_b, in_signed);
                tag_q[0] <= in_tag;
            end
            for (int k = 1; k < LAT; k++) begin
                if (adv[k]) begin
                    vld_q[k]  <= vld_q[k-1];
                    prod_q[k] <= prod_d[k];
                    tag_q[k]  <= tag_q[k-1];
                end
            end
        end
    end

    assign out_valid   = vld_q[LAT-1];
    assign out_product = prod_q[LAT-1];
    assign out_tag     = tag_q[LAT-1];
    assign occupancy   = occ_q;

endmodule
